// File: rtl/sdram_init_refresh.sv
// sdram_init_refresh
// SDRAM power-up and periodic-refresh sequencer. After reset it runs the
// power-up sequence (CKE wait, PRECHARGE-all, INIT_REFRESHES auto-refreshes,
// LOAD_MODE). It then counts refresh ticks into a saturating debt and serves
// that debt one AUTO_REFRESH at a time through a REQ/ACK handshake.
// Ports:
//   CLK            in   system clock, rising edge
//   RESET          in   asynchronous active-low reset
//   CLKE           out  SDRAM CKE
//   CMD[3:0]       out  {CS_n,RAS_n,CAS_n,WE_n}
//   ARAM[12:0]     out  multiplexed address bus
//   INIT_DONE      out  power-up sequence complete
//   BUSY           out  block owns the command bus
//   REFRESH_REQ    out  refresh debt pending and block idle
//   REFRESH_URGENT out  refresh debt at its saturation limit
//   REFRESH_ACK    in   one-cycle grant from the arbiter
module sdram_init_refresh #(
  parameter logic [12:0] MODE             = 13'h0022,
  parameter int          POWERUP_CYCLES   = 8192,
  parameter int          TRP              = 3,
  parameter int          TRFC             = 8,
  parameter int          TMRD             = 2,
  parameter int          INIT_REFRESHES   = 2,
  parameter int          REFRESH_INTERVAL = 390,
  parameter int          MAX_PENDING      = 7
) (
  input  logic        CLK,
  input  logic        RESET,
  output logic        CLKE,
  output logic [3:0]  CMD,
  output logic [12:0] ARAM,
  output logic        INIT_DONE,
  output logic        BUSY,
  output logic        REFRESH_REQ,
  output logic        REFRESH_URGENT,
  input  logic        REFRESH_ACK
);

  localparam logic [3:0] CMD_INHIBIT = 4'b1111;
  localparam logic [3:0] CMD_NOP     = 4'b0111;
  localparam logic [3:0] CMD_PRE     = 4'b0010;
  localparam logic [3:0] CMD_AREF    = 4'b0001;
  localparam logic [3:0] CMD_LMR     = 4'b0000;

  localparam int WAIT_A   = (TRP > TRFC) ? TRP : TRFC;
  localparam int WAIT_B   = (WAIT_A > TMRD) ? WAIT_A : TMRD;
  localparam int WAIT_MAX = (WAIT_B > POWERUP_CYCLES) ? WAIT_B : POWERUP_CYCLES;
  localparam int CNT_W    = $clog2(WAIT_MAX);
  localparam int TMR_W    = $clog2(REFRESH_INTERVAL);
  localparam int REF_W    = $clog2(INIT_REFRESHES + 1);

  localparam logic [CNT_W-1:0] PWR_LAST  = CNT_W'(POWERUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] CKE_AT    = CNT_W'(POWERUP_CYCLES / 2);
  localparam logic [CNT_W-1:0] TRP_LAST  = CNT_W'(TRP - 2);
  localparam logic [CNT_W-1:0] TRFC_LAST = CNT_W'(TRFC - 2);
  localparam logic [CNT_W-1:0] TMRD_LAST = CNT_W'(TMRD - 2);
  localparam logic [TMR_W-1:0] TMR_LAST  = TMR_W'(REFRESH_INTERVAL - 1);
  localparam logic [REF_W-1:0] REF_TOTAL = REF_W'(INIT_REFRESHES);
  localparam logic [3:0]       DEBT_MAX  = 4'(MAX_PENDING);

  typedef enum logic [2:0] {
    S_PWRUP, S_PRE, S_TRP_WAIT, S_REF, S_TRFC_WAIT, S_LMR, S_TMRD_WAIT, S_IDLE
  } state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [TMR_W-1:0]   timer;
  logic [REF_W-1:0]   refs;
  logic [3:0]         debt;
  logic               periodic;
  logic               timer_run;
  logic               tick;
  logic               accept;

  // Saturating debt update; a simultaneous tick and grant cancel out.
  function automatic logic [3:0] debt_update(input logic [3:0] d,
                                             input logic tick_i,
                                             input logic take_i);
    logic [3:0] r;
    r = d;
    if (tick_i && !take_i && (d != DEBT_MAX)) r = d + 4'd1;
    if (take_i && !tick_i)                    r = d - 4'd1;
    return r;
  endfunction

  function automatic state_t after_refresh(input logic periodic_i,
                                           input logic [REF_W-1:0] issued);
    state_t s;
    if (periodic_i)               s = S_IDLE;
    else if (issued < REF_TOTAL)  s = S_REF;
    else                          s = S_LMR;
    return s;
  endfunction

  // The timer starts on the edge the FSM first sits in IDLE, one edge
  // before INIT_DONE itself is visible.
  assign timer_run = INIT_DONE || (state == S_IDLE);
  assign tick      = timer_run && (timer == '0);
  assign accept    = REFRESH_ACK && REFRESH_REQ && (state == S_IDLE);

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state          <= S_PWRUP;
      cnt            <= '0;
      timer          <= TMR_LAST;
      refs           <= '0;
      debt           <= '0;
      periodic       <= 1'b0;
      CLKE           <= 1'b0;
      CMD            <= CMD_INHIBIT;
      ARAM           <= '0;
      INIT_DONE      <= 1'b0;
      BUSY           <= 1'b1;
      REFRESH_REQ    <= 1'b0;
      REFRESH_URGENT <= 1'b0;
    end else begin
      // Outputs reflect the state held before this edge.
      CMD            <= CMD_NOP;
      ARAM           <= '0;
      BUSY           <= (state != S_IDLE);
      INIT_DONE      <= INIT_DONE | (state == S_IDLE);
      REFRESH_REQ    <= (state == S_IDLE) && (debt != 4'd0);
      REFRESH_URGENT <= (debt == DEBT_MAX);
      debt           <= debt_update(debt, tick, accept);
      if (timer_run) timer <= (timer == '0) ? TMR_LAST : timer - 1'b1;

      case (state)
        S_PWRUP: begin
          cnt  <= cnt + 1'b1;
          CLKE <= CLKE | (cnt >= CKE_AT);
          CMD  <= (cnt >= CKE_AT) ? CMD_NOP : CMD_INHIBIT;
          if (cnt == PWR_LAST) begin
            cnt   <= '0;
            state <= S_PRE;
          end
        end
        S_PRE: begin
          CMD   <= CMD_PRE;
          ARAM  <= 13'h0400;
          cnt   <= '0;
          state <= (TRP == 1) ? S_REF : S_TRP_WAIT;
        end
        S_TRP_WAIT: begin
          cnt <= cnt + 1'b1;
          if (cnt == TRP_LAST) state <= S_REF;
        end
        S_REF: begin
          CMD <= CMD_AREF;
          cnt <= '0;
          if (!periodic) refs <= refs + 1'b1;
          state <= (TRFC == 1) ? after_refresh(periodic, refs + 1'b1) : S_TRFC_WAIT;
        end
        S_TRFC_WAIT: begin
          cnt <= cnt + 1'b1;
          if (cnt == TRFC_LAST) state <= after_refresh(periodic, refs);
        end
        S_LMR: begin
          CMD   <= CMD_LMR;
          ARAM  <= MODE;
          cnt   <= '0;
          state <= (TMRD == 1) ? S_IDLE : S_TMRD_WAIT;
        end
        S_TMRD_WAIT: begin
          cnt <= cnt + 1'b1;
          if (cnt == TMRD_LAST) state <= S_IDLE;
        end
        S_IDLE: begin
          if (accept) begin
            periodic <= 1'b1;
            state    <= S_PRE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_init_refresh.sv
module tb_sdram_init_refresh;

  localparam logic [12:0] MODE_V = 13'h0032;
  localparam logic [3:0]  INH = 4'b1111, NOP = 4'b0111, PRE = 4'b0010,
                          ARF = 4'b0001, LMR = 4'b0000;

  logic        CLK = 1'b0;
  logic        RESET = 1'b0;
  logic        REFRESH_ACK = 1'b0;
  logic        CLKE, INIT_DONE, BUSY, REFRESH_REQ, REFRESH_URGENT;
  logic [3:0]  CMD;
  logic [12:0] ARAM;
  logic [21:0] obs;

  int total = 0;
  int bad   = 0;
  int edge_n = -1;

  sdram_init_refresh #(
    .MODE(MODE_V), .POWERUP_CYCLES(16), .TRP(2), .TRFC(4), .TMRD(2),
    .INIT_REFRESHES(2), .REFRESH_INTERVAL(20), .MAX_PENDING(3)
  ) dut (
    .CLK(CLK), .RESET(RESET), .CLKE(CLKE), .CMD(CMD), .ARAM(ARAM),
    .INIT_DONE(INIT_DONE), .BUSY(BUSY), .REFRESH_REQ(REFRESH_REQ),
    .REFRESH_URGENT(REFRESH_URGENT), .REFRESH_ACK(REFRESH_ACK)
  );

  always #5 CLK = ~CLK;

  assign obs = {CLKE, CMD, ARAM, INIT_DONE, BUSY, REFRESH_REQ, REFRESH_URGENT};

  initial begin
    #100000;
    $display("FAIL watchdog edge=%0d got=timeout exp=finish", edge_n);
    $fatal(1, "watchdog expired");
  end

  function automatic logic [21:0] pk(input logic c, input logic [3:0] cm,
                                     input logic [12:0] a, input logic d,
                                     input logic b, input logic r, input logic u);
    return {c, cm, a, d, b, r, u};
  endfunction

  // Expected outputs after edge e of the power-up sequence (P=16).
  function automatic logic [21:0] exp_init(input int e);
    logic [3:0]  cm;
    logic [12:0] a;
    cm = (e < 8) ? INH : NOP;
    a  = 13'h0;
    if (e == 16) begin cm = PRE; a = 13'h0400; end
    if (e == 18 || e == 22) cm = ARF;
    if (e == 26) begin cm = LMR; a = MODE_V; end
    return pk(e >= 8, cm, a, e >= 28, e < 28, 1'b0, 1'b0);
  endfunction

  task automatic step();
    @(posedge CLK);
    #1;
    edge_n++;
  endtask

  task automatic release_reset();
    @(negedge CLK);
    RESET  = 1'b1;
    edge_n = -1;
  endtask

  task automatic run_init(input string tag, input bit pulse_ack);
    logic [21:0] ex;
    RESET = 1'b0;
    repeat (2) @(posedge CLK);
    release_reset();
    for (int e = 0; e <= 28; e++) begin
      REFRESH_ACK = pulse_ack && (e == 5 || e == 17 || e == 20 || e == 27);
      step();
      REFRESH_ACK = 1'b0;
      ex = exp_init(edge_n);
      total++;
      if (obs !== ex) begin
        bad++;
        $display("FAIL %s e=%0d got=%h exp=%h", tag, edge_n, obs, ex);
      end
    end
  endtask

  task automatic test_reset();
    logic [21:0] ex;
    ex = pk(1'b0, INH, 13'h0, 1'b0, 1'b1, 1'b0, 1'b0);
    RESET = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    total++;
    if (obs !== ex) begin
      bad++;
      $display("FAIL reset_state got=%h exp=%h", obs, ex);
    end
  endtask

  task automatic test_init();
    run_init("init", 1'b0);
  endtask

  // Continues from test_init: debt build-up, saturation, drain, tick+grant.
  task automatic test_refresh_debt();
    logic [21:0] ex;
    logic [3:0]  cm;
    logic [12:0] a;
    logic        b, r, u;
    for (int e = 29; e <= 150; e++) begin
      REFRESH_ACK = (e == 110 || e == 113 || e == 127 || e == 135 || e == 143);
      step();
      REFRESH_ACK = 1'b0;
      cm = NOP;
      a  = 13'h0;
      if (e == 111 || e == 128 || e == 136 || e == 144) begin cm = PRE; a = 13'h0400; end
      if (e == 113 || e == 130 || e == 138 || e == 146) cm = ARF;
      b = (e >= 111 && e <= 116) || (e >= 128 && e <= 133) ||
          (e >= 136 && e <= 141) || (e >= 144 && e <= 149);
      r = (e >= 48 && e <= 110) || (e >= 117 && e <= 127) ||
          (e >= 134 && e <= 135) || (e >= 142 && e <= 143) || (e >= 150);
      u = (e >= 88 && e <= 110);
      ex = pk(1'b1, cm, a, 1'b1, b, r, u);
      total++;
      if (obs !== ex) begin
        bad++;
        $display("FAIL debt e=%0d got=%h exp=%h", edge_n, obs, ex);
      end
    end
  endtask

  task automatic test_ack_debt_one();
    logic [21:0] ex;
    logic [3:0]  cm;
    logic [12:0] a;
    run_init("init2", 1'b0);
    for (int e = 29; e <= 70; e++) begin
      REFRESH_ACK = (e == 50);
      step();
      REFRESH_ACK = 1'b0;
      cm = (e == 53) ? ARF : NOP;
      a  = 13'h0;
      if (e == 51) begin cm = PRE; a = 13'h0400; end
      ex = pk(1'b1, cm, a, 1'b1, (e >= 51 && e <= 56),
              (e >= 48 && e <= 50) || (e >= 68), 1'b0);
      total++;
      if (obs !== ex) begin
        bad++;
        $display("FAIL ack1 e=%0d got=%h exp=%h", edge_n, obs, ex);
      end
    end
  endtask

  task automatic test_reset_mid_init();
    logic [21:0] ex;
    RESET = 1'b0;
    repeat (2) @(posedge CLK);
    release_reset();
    for (int e = 0; e <= 19; e++) begin
      step();
      ex = exp_init(edge_n);
      total++;
      if (obs !== ex) begin
        bad++;
        $display("FAIL pre_abort e=%0d got=%h exp=%h", edge_n, obs, ex);
      end
    end
    // Assert reset between edges, well away from the next rising edge.
    #2;
    RESET = 1'b0;
    #1;
    ex = pk(1'b0, INH, 13'h0, 1'b0, 1'b1, 1'b0, 1'b0);
    total++;
    if (obs !== ex) begin
      bad++;
      $display("FAIL async_reset got=%h exp=%h", obs, ex);
    end
    run_init("replay_ack", 1'b1);
    for (int e = 29; e <= 49; e++) begin
      step();
      ex = pk(1'b1, NOP, 13'h0, 1'b1, 1'b0, e >= 48, 1'b0);
      total++;
      if (obs !== ex) begin
        bad++;
        $display("FAIL replay_req e=%0d got=%h exp=%h", edge_n, obs, ex);
      end
    end
  endtask

  initial begin
    test_reset();
    test_init();
    test_refresh_debt();
    test_ack_debt_one();
    test_reset_mid_init();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
